// File: rtl/legv8_multicycle_control.sv
// rtl/legv8_multicycle_control.sv - LEGv8 multi-cycle main control FSM (FETCH/DECODE/EXEC/MEM/WB)
// Optional MEM_HANDSHAKE_EN adds MemReady; MEM then stalls until the data memory acknowledges.
module legv8_multicycle_control #(
   parameter int FETCH_WAIT = 0,
   parameter int RETIRE_W   = 16
) (
   input  logic                CLK,
   input  logic                Reset,
   input  logic [10:0]         Opcode,
   input  logic                Zero,
`ifdef MEM_HANDSHAKE_EN
   input  logic                MemReady,
`endif
   output logic                PCWrite,
   output logic                IRWrite,
   output logic                Reg2Loc,
   output logic                ALUSrc,
   output logic [1:0]          ALUOp,
   output logic                MemRead,
   output logic                MemWrite,
   output logic                MemtoReg,
   output logic                RegWrite,
   output logic                Illegal,
   output logic                InstrDone,
   output logic [RETIRE_W-1:0] RetireCount
);

   typedef enum logic [2:0] {
      st_fetch,
      st_decode,
      st_exec,
      st_mem,
      st_wb,
      st_illegal
   } state_t;

   typedef enum logic [2:0] {
      cls_r,
      cls_ldur,
      cls_stur,
      cls_cbz,
      cls_b,
      cls_ill
   } cls_t;

   localparam logic [3:0] fetch_wait_c = 4'(FETCH_WAIT);

   state_t              state;
   state_t              state_nxt;
   logic [3:0]          wait_cnt;
   logic [3:0]          wait_nxt;
   logic [10:0]         op_reg;
   logic [RETIRE_W-1:0] retire_cnt;
   cls_t                dec_cls;
   cls_t                cur_cls;
   logic                mem_ready;

   function automatic cls_t classify(input logic [10:0] op);
      cls_t c;
      if (op == 11'b10001010000 || op == 11'b10101010000 || op == 11'b10001011000 ||
          op == 11'b11001011000 || op == 11'b11101010000)
         c = cls_r;
      else if (op == 11'b11111000010)
         c = cls_ldur;
      else if (op == 11'b11111000000)
         c = cls_stur;
      else if (op[10:3] == 8'b10110100)
         c = cls_cbz;
      else if (op[10:5] == 6'b000101)
         c = cls_b;
      else
         c = cls_ill;
      return c;
   endfunction

`ifdef MEM_HANDSHAKE_EN
   assign mem_ready = MemReady;
`else
   assign mem_ready = 1'b1;
`endif

   // DECODE classifies the live IR; later states use the opcode captured on entry to EXEC
   assign dec_cls = classify(Opcode);
   assign cur_cls = classify(op_reg);

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state      <= st_fetch;
         wait_cnt   <= 4'd0;
         op_reg     <= 11'd0;
         retire_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         if (state == st_decode && state_nxt == st_exec)
            op_reg <= Opcode;
         if (InstrDone)
            retire_cnt <= retire_cnt + RETIRE_W'(1);
      end
   end

   always_comb begin
      state_nxt   = state;
      wait_nxt    = wait_cnt;
      PCWrite     = 1'b0;
      IRWrite     = 1'b0;
      Reg2Loc     = 1'b0;
      ALUSrc      = 1'b0;
      ALUOp       = 2'b00;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      Illegal     = 1'b0;
      InstrDone   = 1'b0;
      RetireCount = retire_cnt;

      case (state)
         st_fetch: begin
            if (wait_cnt != fetch_wait_c) begin
               wait_nxt = wait_cnt + 4'd1;
            end else begin
               IRWrite   = 1'b1;
               PCWrite   = 1'b1;
               wait_nxt  = 4'd0;
               state_nxt = st_decode;
            end
         end

         st_decode: begin
            state_nxt = (dec_cls == cls_ill) ? st_illegal : st_exec;
         end

         st_exec: begin
            case (cur_cls)
               cls_r: begin
                  ALUOp     = 2'b10;
                  state_nxt = st_wb;
               end
               cls_ldur: begin
                  ALUSrc    = 1'b1;
                  state_nxt = st_mem;
               end
               cls_stur: begin
                  ALUSrc    = 1'b1;
                  Reg2Loc   = 1'b1;
                  state_nxt = st_mem;
               end
               cls_cbz: begin
                  ALUOp     = 2'b01;
                  Reg2Loc   = 1'b1;
                  PCWrite   = Zero;
                  InstrDone = 1'b1;
                  state_nxt = st_fetch;
               end
               cls_b: begin
                  PCWrite   = 1'b1;
                  InstrDone = 1'b1;
                  state_nxt = st_fetch;
               end
               default: state_nxt = st_fetch;
            endcase
         end

         st_mem: begin
            // access strobes stay up for as long as the memory withholds MemReady
            if (cur_cls == cls_ldur) begin
               MemRead = 1'b1;
               if (mem_ready)
                  state_nxt = st_wb;
            end else begin
               MemWrite = 1'b1;
               if (mem_ready) begin
                  InstrDone = 1'b1;
                  state_nxt = st_fetch;
               end
            end
         end

         st_wb: begin
            RegWrite  = 1'b1;
            MemtoReg  = (cur_cls == cls_ldur);
            InstrDone = 1'b1;
            state_nxt = st_fetch;
         end

         st_illegal: begin
            Illegal   = 1'b1;
            state_nxt = st_fetch;
         end

         default: state_nxt = st_fetch;
      endcase

      // a Reset cycle silences every output, even mid-instruction
      if (Reset) begin
         PCWrite     = 1'b0;
         IRWrite     = 1'b0;
         Reg2Loc     = 1'b0;
         ALUSrc      = 1'b0;
         ALUOp       = 2'b00;
         MemRead     = 1'b0;
         MemWrite    = 1'b0;
         MemtoReg    = 1'b0;
         RegWrite    = 1'b0;
         Illegal     = 1'b0;
         InstrDone   = 1'b0;
         RetireCount = '0;
      end
   end

endmodule

// File: tb/tb_legv8_multicycle_control.sv
// tb/tb_legv8_multicycle_control.sv - randomized model-checked bench for legv8_multicycle_control
// dut0: FETCH_WAIT=0 RETIRE_W=16; dut1: FETCH_WAIT=2 RETIRE_W=4 (counter wrap)
module tb_legv8_multicycle_control;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        reset0 = 1'b1, reset1 = 1'b1;
   logic [10:0] opcode0 = '0, opcode1 = '0;
   logic        zero0 = 1'b0, zero1 = 1'b0;

   logic [1:0]  pcwrite, irwrite, reg2loc, alusrc, memread, memwrite, memtoreg, regwrite;
   logic [1:0]  illegal, instrdone;
   logic [1:0]  aluop0, aluop1;
   logic [15:0] rc0;
   logic [3:0]  rc1;

   legv8_multicycle_control #(.FETCH_WAIT(0), .RETIRE_W(16)) dut0 (
      .CLK(CLK), .Reset(reset0), .Opcode(opcode0), .Zero(zero0),
`ifdef MEM_HANDSHAKE_EN
      .MemReady(1'b1),
`endif
      .PCWrite(pcwrite[0]), .IRWrite(irwrite[0]), .Reg2Loc(reg2loc[0]), .ALUSrc(alusrc[0]),
      .ALUOp(aluop0), .MemRead(memread[0]), .MemWrite(memwrite[0]), .MemtoReg(memtoreg[0]),
      .RegWrite(regwrite[0]), .Illegal(illegal[0]), .InstrDone(instrdone[0]), .RetireCount(rc0)
   );

   legv8_multicycle_control #(.FETCH_WAIT(2), .RETIRE_W(4)) dut1 (
      .CLK(CLK), .Reset(reset1), .Opcode(opcode1), .Zero(zero1),
`ifdef MEM_HANDSHAKE_EN
      .MemReady(1'b1),
`endif
      .PCWrite(pcwrite[1]), .IRWrite(irwrite[1]), .Reg2Loc(reg2loc[1]), .ALUSrc(alusrc[1]),
      .ALUOp(aluop1), .MemRead(memread[1]), .MemWrite(memwrite[1]), .MemtoReg(memtoreg[1]),
      .RegWrite(regwrite[1]), .Illegal(illegal[1]), .InstrDone(instrdone[1]), .RetireCount(rc1)
   );

   typedef struct {
      logic [11:0] sig;
      logic [15:0] cnt;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   mcnt[2];
   int   ncmp = 0;
   int   nfail = 0;

   localparam logic [10:0] op_add  = 11'b10001011000;
   localparam logic [10:0] op_ldur = 11'b11111000010;
   localparam logic [10:0] op_stur = 11'b11111000000;

   // {pcw irw r2l src aluop[1:0] mr mw m2r rw ill done}
   function automatic logic [11:0] mk(input bit pcw, input bit irw, input bit r2l, input bit src,
                                      input logic [1:0] aop, input bit mr, input bit mw,
                                      input bit m2r, input bit rw, input bit ill, input bit done);
      return {pcw, irw, r2l, src, aop, mr, mw, m2r, rw, ill, done};
   endfunction

   function automatic void push(input int d, input logic [11:0] sig);
      exp_t e;
      int   mask;
      mask  = (d == 0) ? 32'hFFFF : 32'hF;
      e.sig = sig;
      e.cnt = 16'(mcnt[d] & mask);
      if (sig[0])
         mcnt[d] = (mcnt[d] + 1) & mask;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endfunction

   // 0 R, 1 LDUR, 2 STUR, 3 CBZ, 4 B, 5 illegal
   function automatic int classify(input logic [10:0] op);
      logic [10:0] rl [5];
      rl = '{11'b10001010000, 11'b10101010000, 11'b10001011000, 11'b11001011000, 11'b11101010000};
      foreach (rl[i]) if (op == rl[i]) return 0;
      if (op == op_ldur) return 1;
      if (op == op_stur) return 2;
      if (op[10:3] == 8'b10110100) return 3;
      if (op[10:5] == 6'b000101) return 4;
      return 5;
   endfunction

   // Queues the whole expected per-cycle output trace of one instruction; returns its length.
   function automatic int expect_instr(input int d, input logic [10:0] op, input bit z);
      int n0;
      int waitc;
      n0    = (d == 0) ? q0.size() : q1.size();
      waitc = (d == 0) ? 0 : 2;
      for (int i = 0; i < waitc; i++) push(d, 12'h000);
      push(d, mk(1,1,0,0,2'b00,0,0,0,0,0,0));
      push(d, 12'h000);
      case (classify(op))
         0: begin
            push(d, mk(0,0,0,0,2'b10,0,0,0,0,0,0));
            push(d, mk(0,0,0,0,2'b00,0,0,0,1,0,1));
         end
         1: begin
            push(d, mk(0,0,0,1,2'b00,0,0,0,0,0,0));
            push(d, mk(0,0,0,0,2'b00,1,0,0,0,0,0));
            push(d, mk(0,0,0,0,2'b00,0,0,1,1,0,1));
         end
         2: begin
            push(d, mk(0,0,1,1,2'b00,0,0,0,0,0,0));
            push(d, mk(0,0,0,0,2'b00,0,1,0,0,0,1));
         end
         3: push(d, mk(z,0,1,0,2'b01,0,0,0,0,0,1));
         4: push(d, mk(1,0,0,0,2'b00,0,0,0,0,0,1));
         default: push(d, mk(0,0,0,0,2'b00,0,0,0,0,1,0));
      endcase
      return ((d == 0) ? q0.size() : q1.size()) - n0;
   endfunction

   function automatic logic [10:0] rand_op();
      logic [10:0] rl [5];
      rl = '{11'b10001010000, 11'b10101010000, 11'b10001011000, 11'b11001011000, 11'b11101010000};
      case ($urandom_range(0, 6))
         0: return rl[$urandom_range(0, 4)];
         1: return op_ldur;
         2: return op_stur;
         3: return {8'b10110100, 3'($urandom)};
         4: return {6'b000101, 5'($urandom)};
         5: return 11'($urandom);
         default: return 11'd0;
      endcase
   endfunction

   task automatic check_val(input string name, input int got, input int want);
      ncmp++;
      if (got != want) begin
         nfail++;
         $display("FAIL %s got %0d want %0d at t=%0t", name, got, want, $time);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic drive(input int d, input logic [10:0] op, input bit z, input bit rst);
      if (d == 0) begin opcode0 = op; zero0 = z; reset0 = rst; end
      else        begin opcode1 = op; zero1 = z; reset1 = rst; end
   endtask

   task automatic do_reset(input int d, input int n);
      mcnt[d] = 0;
      for (int i = 0; i < n; i++) push(d, 12'h000);
      drive(d, 11'($urandom), 1'($urandom), 1'b1);
      wait_cycles(n);
      drive(d, 11'($urandom), 1'($urandom), 1'b0);
   endtask

   task automatic run_instr(input int d, input logic [10:0] op, input bit z, output int n);
      n = expect_instr(d, op, z);
      drive(d, op, z, 1'b0);
      wait_cycles(n);
   endtask

   // One compare process: every cycle with a queued expectation is checked.
   task automatic cmp(input int d, input exp_t e);
      logic [11:0] act;
      logic [15:0] cnt;
      if (d == 0) begin
         act = {pcwrite[0], irwrite[0], reg2loc[0], alusrc[0], aluop0, memread[0], memwrite[0],
                memtoreg[0], regwrite[0], illegal[0], instrdone[0]};
         cnt = rc0;
      end else begin
         act = {pcwrite[1], irwrite[1], reg2loc[1], alusrc[1], aluop1, memread[1], memwrite[1],
                memtoreg[1], regwrite[1], illegal[1], instrdone[1]};
         cnt = {12'd0, rc1};
      end
      ncmp++;
      if (act !== e.sig) begin
         nfail++;
         $display("FAIL dut%0d ctl t=%0t got %b want %b (pcw irw r2l src aluop mr mw m2r rw ill done)",
                  d, $time, act, e.sig);
      end
      ncmp++;
      if (cnt !== e.cnt) begin
         nfail++;
         $display("FAIL dut%0d retire t=%0t got %0d want %0d", d, $time, cnt, e.cnt);
      end
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (q0.size() != 0) begin e = q0.pop_front(); cmp(0, e); end
      if (q1.size() != 0) begin e = q1.pop_front(); cmp(1, e); end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      mcnt[0] = 0;
      mcnt[1] = 0;
      @(posedge CLK);
      #1;
      fork
         begin
            do_reset(0, 3);
            run_instr(0, op_add, 1'($urandom), n);   check_val("add_latency", n, 4);
            run_instr(0, op_ldur, 1'($urandom), n);  check_val("ldur_latency", n, 5);
            run_instr(0, op_stur, 1'($urandom), n);  check_val("stur_latency", n, 4);
            run_instr(0, 11'b10110100011, 1'b1, n);  check_val("cbz_z1_latency", n, 3);
            run_instr(0, 11'b10110100101, 1'b0, n);  check_val("cbz_z0_latency", n, 3);
            run_instr(0, 11'b00000000000, 1'b0, n);  check_val("illegal_latency", n, 3);
            check_val("retire_after_seq", rc0, 5);
            run_instr(0, 11'b00010100110, 1'b0, n);  check_val("b_latency", n, 3);
            // reset lands on the MEM cycle of an LDUR
            push(0, mk(1,1,0,0,2'b00,0,0,0,0,0,0));
            push(0, 12'h000);
            push(0, mk(0,0,0,1,2'b00,0,0,0,0,0,0));
            drive(0, op_ldur, 1'b0, 1'b0);
            wait_cycles(3);
            do_reset(0, 1);
            check_val("retire_after_reset", rc0, 0);
            for (int i = 0; i < 150; i++) run_instr(0, rand_op(), 1'($urandom), n);
         end
         begin
            do_reset(1, 2);
            for (int i = 0; i < 17; i++) run_instr(1, {6'b000101, 5'($urandom)}, 1'($urandom), n);
            check_val("retire_wrap_4bit", rc1, 1);
            for (int i = 0; i < 60; i++) run_instr(1, rand_op(), 1'($urandom), n);
         end
      join
      wait_cycles(2);
      check_val("q0_drained", q0.size(), 0);
      check_val("q1_drained", q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
